array_index_reader_pipe: RTL and testbench

//  Read side of the pipelined flattened-array path: accepts a packed NUM_ELEMS x ELEM_W

---
 rtl/array_index_reader_pipe.sv | 75 +++++++
 tb/tb_array_index_reader_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/array_index_reader_pipe.sv
// array_index_reader_pipe: two-stage valid/ready array element read with clamped out-of-bounds indices
module array_index_reader_pipe #(
  parameter int ELEM_W    = 33,
  parameter int NUM_ELEMS = 4,
  parameter int IDX_W     = 32,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_ELEMS*ELEM_W-1:0] x,
  input  logic [IDX_W-1:0]            idx,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ELEM_W-1:0]           out,
  output logic                        out_oob,
  output logic [CNT_W-1:0]            oob_count
);
  localparam int SW = $clog2(NUM_ELEMS);
  logic                        p0_valid_q, p0_valid_d;
  logic [NUM_ELEMS*ELEM_W-1:0] p0_x_q, p0_x_d;
  logic [IDX_W-1:0]            p0_idx_q, p0_idx_d;
  logic                        p1_valid_q, p1_valid_d;
  logic [ELEM_W-1:0]           out_q, out_d;
  logic                        oob_q, oob_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        p0_adv, p1_adv, oob, p0_ld, p1_ld;
  logic [SW-1:0]               sel;
  logic [ELEM_W-1:0]           elems [NUM_ELEMS];
  genvar i;
  for (i = 0; i < NUM_ELEMS; i++) begin : g_el
    assign elems[i] = p0_x_q[i*ELEM_W +: ELEM_W];
  end
  always_comb begin
    p1_adv     = !p1_valid_q || out_ready;
    p0_adv     = !p0_valid_q || p1_adv;
    p0_ld      = in_valid && p0_adv;
    p1_ld      = p1_adv && p0_valid_q;
    // compare at full index width so high bits are never truncated away
    oob        = p0_idx_q >= IDX_W'(NUM_ELEMS);
    sel        = oob ? SW'(NUM_ELEMS - 1) : p0_idx_q[SW-1:0];
    p0_valid_d = p0_adv ? in_valid : p0_valid_q;
    p0_x_d     = p0_ld ? x : p0_x_q;
    p0_idx_d   = p0_ld ? idx : p0_idx_q;
    p1_valid_d = p1_adv ? p0_valid_q : p1_valid_q;
    out_d      = p1_ld ? elems[sel] : out_q;
    oob_d      = p1_ld ? oob : oob_q;
    cnt_d      = (p1_valid_q && out_ready && oob_q && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_valid_q <= 1'b0;
      p0_x_q     <= '0;
      p0_idx_q   <= '0;
      p1_valid_q <= 1'b0;
      out_q      <= '0;
      oob_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      p0_valid_q <= p0_valid_d;
      p0_x_q     <= p0_x_d;
      p0_idx_q   <= p0_idx_d;
      p1_valid_q <= p1_valid_d;
      out_q      <= out_d;
      oob_q      <= oob_d;
      cnt_q      <= cnt_d;
    end
  end
  assign in_ready  = p0_adv;
  assign out_valid = p1_valid_q;
  assign out       = out_q;
  assign out_oob   = oob_q;
  assign oob_count = cnt_q;
endmodule

// File: tb/tb_array_index_reader_pipe.sv
// tb_array_index_reader_pipe: scoreboard bench with a CNT_W=2 twin instance for saturation
module tb_array_index_reader_pipe;
  logic         clk = 0;
  logic         rst = 1;
  logic         in_valid = 0;
  logic [131:0] x = '0;
  logic [31:0]  idx = '0;
  logic         out_ready = 1;
  logic         in_ready, out_valid, out_oob;
  logic [32:0]  out;
  logic [15:0]  oob_count;
  logic         in_ready2, out_valid2, out_oob2;
  logic [32:0]  out2;
  logic [1:0]   oob_count2;
  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  int exp_sat = 0;
  logic [33:0] sb [$];
  localparam logic [131:0] XV = {33'h0_0000_0004, 33'h0_0000_0003, 33'h1_0000_0002, 33'h0_0000_002A};
  localparam logic [32:0] E0 = 33'h0_0000_002A, E1 = 33'h1_0000_0002, E2 = 33'h0_0000_0003, E3 = 33'h0_0000_0004;

  array_index_reader_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .idx(idx),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_oob(out_oob), .oob_count(oob_count)
  );
  array_index_reader_pipe #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .x(x), .idx(idx),
    .out_valid(out_valid2), .out_ready(out_ready), .out(out2), .out_oob(out_oob2), .oob_count(oob_count2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic        prev_v = 0, prev_r = 0;
  logic [33:0] prev_d = '0;
  logic [33:0] e;
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 0;
      exp_sat = 0;
      prev_v  = 0;
    end else begin
      if (prev_v && !prev_r) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'({out_oob, out}), 64'(prev_d));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("out", 64'(out), 64'(e[32:0]));
          check("out_oob", 64'(out_oob), 64'(e[33]));
          check("out2", 64'({out_oob2, out2}), 64'(e));
          check("oob_count", 64'(oob_count), 64'(exp_cnt));
          check("oob_count_sat", 64'(oob_count2), 64'(exp_sat));
          if (e[33]) begin
            exp_cnt++;
            if (exp_sat < 3) exp_sat++;
          end
        end
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_d = {out_oob, out};
    end
  end

  task automatic send(input logic [31:0] iv, input logic [32:0] eo, input logic eb, output int waits);
    bit acc = 0;
    waits = 0;
    in_valid = 1;
    x = XV;
    idx = iv;
    while (!acc && waits < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) sb.push_back({eb, eo});
      else waits++;
      #1;
    end
    in_valid = 0;
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  int w, wsum, acc_n;
  logic [32:0] etab [4];
  initial begin
    etab[0] = E0; etab[1] = E1; etab[2] = E2; etab[3] = E3;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_out_oob", 64'(out_oob), 64'd0);
    check("rst_oob_count", 64'(oob_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send(32'd1, E1, 1'b0, w);
    drain();
    send(32'd7, E3, 1'b1, w);
    send(32'h8000_0000, E3, 1'b1, w);
    send(32'd4, E3, 1'b1, w);
    drain();
    check("oob_count_after_t2", 64'(oob_count), 64'd3);
    wsum = 0;
    for (int k = 0; k < 4; k++) begin
      send(32'(k), etab[k], 1'b0, w);
      wsum += w;
    end
    check("b2b_no_stall", 64'(wsum), 64'd0);
    drain();
    out_ready = 0;
    in_valid = 1;
    x = XV;
    idx = 32'd2;
    acc_n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      w = int'(in_ready);
      @(posedge clk);
      if (w != 0) begin
        sb.push_back({1'b0, etab[2 - acc_n]});
        acc_n++;
        #1 idx = 32'(2 - acc_n);
      end else #1;
    end
    check("stall_accepts", 64'(acc_n), 64'd2);
    @(negedge clk);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 1;
    drain();
    send(32'd9, E3, 1'b1, w);
    send(32'hFFFF_FFFF, E3, 1'b1, w);
    drain();
    check("oob_count_total", 64'(oob_count), 64'd5);
    check("oob_count_saturated", 64'(oob_count2), 64'd3);
    out_ready = 0;
    send(32'd5, E3, 1'b1, w);
    send(32'd0, E0, 1'b0, w);
    @(posedge clk); #1;
    rst = 1;
    sb.delete();
    @(posedge clk); #1;
    rst = 0;
    out_ready = 1;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_oob_count", 64'(oob_count), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    send(32'd6, E3, 1'b1, w);
    drain();
    check("post_rst_oob_count", 64'(oob_count), 64'd1);
    check("post_rst_oob_count_sat", 64'(oob_count2), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
